// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run controller for the serial pattern detector.
// A run starts in IDLE, searches the qualified bit stream for a latched
// pattern in SEARCH, counts matches, and ends on a target count or abort.
// A single DONE cycle pulses done before returning to IDLE.
//
// Optional build macro: SEQ_DETECT_TIMEOUT_EN. It adds an idle-cycle timeout
// that ends a run with done=1 and timed_out=1.
//
// Ports:
//   clk, rst_n           rising-edge clock, async active-low reset
//   cfg_pattern/len      pattern (bit [len-1] arrives first) and its length
//   cfg_overlap          1 = matches may share bits, 0 = history restarts
//   cfg_target           matches to finish (0 = run until abort)
//   cfg_timeout          idle-cycle limit (timeout build only)
//   start, abort         run control; abort wins over start
//   bit_valid, bit_in    serial input stream
//   busy, done           in-SEARCH flag, completion pulse
//   match_pulse          one pulse per match, aligned with match_count
//   match_count          matches in the current or last run
//   timed_out            last run ended by timeout (held until next start)
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int TO_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [4:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic [TO_W-1:0]    cfg_timeout,
  input  logic               start,
  input  logic               abort,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               busy,
  output logic               done,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic               timed_out
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

  localparam logic [4:0] MAX_L = 5'(MAX_LEN);

  state_t             state, state_nxt;
  logic [MAX_LEN-1:0] pat_q, pat_nxt;
  logic [4:0]         len_q, len_nxt;
  logic               ovl_q, ovl_nxt;
  logic [CNT_W-1:0]   tgt_q, tgt_nxt;
  logic [MAX_LEN-1:0] history, hist_nxt;
  logic [4:0]         fill, fill_nxt;
  logic [CNT_W-1:0]   cnt_nxt, cnt_inc;
  logic               pulse_nxt;
  logic [4:0]         len_eff;
  logic [MAX_LEN-1:0] hist_sh, mask;
  logic               hit;

`ifdef SEQ_DETECT_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_nxt;
  logic [TO_W-1:0] idle_cnt, idle_nxt;
  logic            tout_q, tout_nxt;
`else
  logic unused_timeout;
  assign unused_timeout = ^cfg_timeout;
`endif

  always_comb begin
    // out-of-range lengths are folded into 1..MAX_LEN before latching
    len_eff = (cfg_len == 5'd0) ? 5'd1 : ((cfg_len > MAX_L) ? MAX_L : cfg_len);
    hist_sh = {history[MAX_LEN-2:0], bit_in};
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len_q));
    // fill+1 covers the bit being shifted in this cycle
    hit = bit_valid && (({1'b0, fill} + 6'd1) >= {1'b0, len_q}) &&
          (((hist_sh ^ pat_q) & mask) == '0);
    cnt_inc = (&match_count) ? match_count : match_count + CNT_W'(1);

    state_nxt = state;
    pat_nxt   = pat_q;
    len_nxt   = len_q;
    ovl_nxt   = ovl_q;
    tgt_nxt   = tgt_q;
    hist_nxt  = history;
    fill_nxt  = fill;
    cnt_nxt   = match_count;
    pulse_nxt = 1'b0;
`ifdef SEQ_DETECT_TIMEOUT_EN
    to_nxt    = to_q;
    idle_nxt  = idle_cnt;
    tout_nxt  = tout_q;
`endif

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nxt = S_SEARCH;
          pat_nxt   = cfg_pattern;
          len_nxt   = len_eff;
          ovl_nxt   = cfg_overlap;
          tgt_nxt   = cfg_target;
          hist_nxt  = '0;
          fill_nxt  = '0;
          cnt_nxt   = '0;
`ifdef SEQ_DETECT_TIMEOUT_EN
          to_nxt    = cfg_timeout;
          idle_nxt  = '0;
          tout_nxt  = 1'b0;
`endif
        end
      end
      S_SEARCH: begin
        if (abort) begin
          // a match coinciding with abort is dropped
          state_nxt = S_IDLE;
        end else begin
          if (bit_valid) begin
            hist_nxt = hist_sh;
            fill_nxt = (fill == MAX_L) ? fill : fill + 5'd1;
          end
          if (hit) begin
            cnt_nxt   = cnt_inc;
            pulse_nxt = 1'b1;
            if (!ovl_q) fill_nxt = '0;
            if ((tgt_q != '0) && (cnt_inc == tgt_q)) state_nxt = S_DONE;
          end
`ifdef SEQ_DETECT_TIMEOUT_EN
          // a match on the expiry cycle wins and restarts the idle count
          if (hit) begin
            idle_nxt = '0;
          end else begin
            idle_nxt = idle_cnt + TO_W'(1);
            if ((to_q != '0) && (idle_nxt == to_q)) begin
              state_nxt = S_DONE;
              tout_nxt  = 1'b1;
            end
          end
`endif
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pat_q       <= '0;
      len_q       <= 5'd1;
      ovl_q       <= 1'b0;
      tgt_q       <= '0;
      history     <= '0;
      fill        <= '0;
      match_count <= '0;
      match_pulse <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      pat_q       <= pat_nxt;
      len_q       <= len_nxt;
      ovl_q       <= ovl_nxt;
      tgt_q       <= tgt_nxt;
      history     <= hist_nxt;
      fill        <= fill_nxt;
      match_count <= cnt_nxt;
      match_pulse <= pulse_nxt;
      busy        <= (state_nxt == S_SEARCH);
      done        <= (state_nxt == S_DONE);
    end
  end

`ifdef SEQ_DETECT_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q     <= '0;
      idle_cnt <= '0;
      tout_q   <= 1'b0;
    end else begin
      to_q     <= to_nxt;
      idle_cnt <= idle_nxt;
      tout_q   <= tout_nxt;
    end
  end
  assign timed_out = tout_q;
`else
  assign timed_out = 1'b0;
`endif

endmodule
